bcd_to_hex_seq_ctrl: RTL and testbench

Sequential BCD-to-binary converter and controller. It accepts a packed multi-digit BCD word and rejects any word containing an invalid digit. It converts by reverse double-dabble, one bit per clock, using an FSM with a start/busy/done handshake. It sits between the BCD capture registers and the hex display/increment datapath in the bcd_to_hex path.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bcd_to_hex_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_to_hex_seq_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared encodings and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] DD_THRESH     = 4'd8;
  localparam logic [3:0] DD_CORR       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a post-shift digit of 8 or more loses 3.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i >= DD_THRESH) ? (dig_i - DD_CORR) : dig_i;

endmodule

// File: rtl/bcd_to_hex_seq_ctrl.sv
// Validates a packed BCD word, then converts it to binary one bit per enabled clock.
// Latency: 2 + BIN_W enabled edges from START to DONE (2 on an invalid digit); START is ignored while BUSY.
module bcd_to_hex_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                START,
  input  logic [4*DIGITS-1:0] IN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [BIN_W-1:0]    OUT
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   out_q, out_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       sh_bcd;
  logic [BIN_W-1:0]       sh_bin;
  logic [BCD_W-1:0]       adj_bcd;
  logic                   digit_bad;

  // The BCD and binary halves shift as one word; only the BCD digits get corrected.
  assign shifted = {bcd_q, bin_q} >> 1;
  assign sh_bcd  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign sh_bin  = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .dig_i (sh_bcd[4*g +: 4]),
      .dig_o (adj_bcd[4*g +: 4])
    );
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] > BCD_DIGIT_MAX) digit_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          bcd_d   = IN;
          bin_d   = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (digit_bad) begin
          err_d   = 1'b1;
          out_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = adj_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q still holds the pre-increment value: this is the BIN_W-th shift.
        if (cnt_q == LAST_CNT) begin
          out_d   = sh_bin;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else if (EN) begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign BUSY = (state_q == S_CHECK) || (state_q == S_SHIFT);
  assign DONE = (state_q == S_DONE);
  assign ERR  = err_q;
  assign OUT  = out_q;

endmodule

// File: tb/tb_bcd_to_hex_seq_ctrl.sv
// Scoreboard bench for bcd_to_hex_seq_ctrl: decimal reference model, latency and handshake checks.
module tb_bcd_to_hex_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  typedef struct packed {
    logic [BIN_W-1:0] out;
    logic             err;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic                start;
  logic [4*DIGITS-1:0] in_bcd;
  logic                busy;
  logic                done;
  logic                err;
  logic [BIN_W-1:0]    out;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   done_cnt;
  logic done_prev;

  bcd_to_hex_seq_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .START (start),
    .IN    (in_bcd),
    .BUSY  (busy),
    .DONE  (done),
    .ERR   (err),
    .OUT   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal evaluation, independent of the shift algorithm.
  function automatic exp_t model(input logic [4*DIGITS-1:0] b);
    exp_t r;
    int   v;
    logic [3:0] d;
    v     = 0;
    r.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) r.err = 1'b1;
      v = v * 10 + int'(d);
    end
    r.out = r.err ? '0 : v[BIN_W-1:0];
    return r;
  endfunction

  // Compare each completed conversion against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      done_cnt++;
      chk("queue_nonempty_at_done", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out", 32'(out), 32'(e.out));
        chk("err", 32'(err), 32'(e.err));
      end
    end
    done_prev = done;
  end

  // Caller sits at a negedge; returns at the negedge where DONE is first seen.
  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input int exp_lat,
                          input int en_off_at, input int en_off_len, input string tag);
    int cyc;
    int busy_cyc;
    bit seen;
    in_bcd = bcd;
    start  = 1'b1;
    exp_q.push_back(model(bcd));
    cyc      = 0;
    busy_cyc = 0;
    seen     = 1'b0;
    while (cyc < 100 && !seen) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (cyc == en_off_at) en = 1'b0;
      if (cyc == en_off_at + en_off_len) en = 1'b1;
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
  endtask

  initial begin
    int d0;
    n_chk     = 0;
    n_fail    = 0;
    done_cnt  = 0;
    done_prev = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b1;
    start     = 1'b0;
    in_bcd    = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_out",  32'(out),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(16'h9999, 16, 0, 0, "c9999");
    chk("c9999_out_hex", 32'(out), 32'h270F);
    @(negedge clk);
    chk("idle_after_done", 32'(done), 32'd0);

    run_conv(16'h12A4, 2, 0, 0, "c12A4");
    chk("c12A4_out_zero", 32'(out), 32'd0);
    @(negedge clk);
    run_conv(16'h0042, 16, 0, 0, "c0042");
    chk("c0042_err_clear", 32'(err), 32'd0);

    @(negedge clk);
    run_conv(16'h1234, 16, 0, 0, "c1234");
    run_conv(16'h0000, 16, 0, 0, "c0000_b2b");

    @(negedge clk);
    run_conv(16'h0999, 21, 4, 5, "c0999_en");
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_stretch_en_low", 32'(done), 32'd1);
    en = 1'b1;
    @(negedge clk);
    chk("done_drop_after_en", 32'(done), 32'd0);

    // Abort at shift iteration 7: no DONE, outputs cleared.
    d0     = done_cnt;
    in_bcd = 16'h9999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out",  32'(out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // START pulses and IN changes while BUSY are ignored.
    d0     = done_cnt;
    in_bcd = 16'h0571;
    start  = 1'b1;
    exp_q.push_back(model(16'h0571));
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 5 || i == 7) ? 1'b1 : 1'b0;
      if (i >= 3) in_bcd = 16'h9999;
    end
    chk("busy_start_single_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_start_out", 32'(out), 32'h023B);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
